j1_uart_io: RTL

Memory-mapped UART peripheral that sits directly on the j1 IO bus. It decodes `io_addr`, accepts `io_wr` and `io_rd` strobes, and returns register data on `io_din`. It serialises TX bytes, deserialises RX bytes into a small FIFO, and drives the j1 `interrupt_request` line while received data is pending and the interrupt is enabled.

---
 rtl/j1_uart_io_pkg.sv | 23 ++
 rtl/uart_rx_fifo.sv | 46 ++++
 rtl/j1_uart_io.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/j1_uart_io_pkg.sv
// Shared definitions for the j1 UART peripheral: default IO map, FLAGS bit
// positions and the state encoding used by both serial FSMs.
package j1_uart_io_pkg;

  localparam logic [15:0] ADDR_DATA_DEF  = 16'h1000;
  localparam logic [15:0] ADDR_FLAGS_DEF = 16'h2000;

  localparam int FLAG_TX_READY = 0;
  localparam int FLAG_RX_VALID = 1;
  localparam int FLAG_OVERRUN  = 2;
  localparam int FLAG_FRAMING  = 3;
  localparam int FLAG_IRQ_EN   = 4;

  // ST_BREAK is only used by RX: after a bad stop bit it waits for the line to idle
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with a combinational head, so the j1 sees the oldest byte in
// the same cycle as its read strobe.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // a pop on the same edge frees the slot the push lands in
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/j1_uart_io.sv
// UART peripheral on the j1 IO bus: DATA/FLAGS registers, 8N1 transmitter,
// oversampled receiver feeding a FIFO, and a level interrupt for pending RX data.
module j1_uart_io
  import j1_uart_io_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] ADDR_DATA    = ADDR_DATA_DEF,
  parameter logic [15:0] ADDR_FLAGS   = ADDR_FLAGS_DEF
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        interrupt_request,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic sel_data, sel_flags, data_rd, data_wr, flags_rd, flags_wr;
  assign sel_data  = (io_addr == ADDR_DATA);
  assign sel_flags = (io_addr == ADDR_FLAGS);
  assign data_rd   = io_rd & sel_data;
  assign data_wr   = io_wr & sel_data;
  assign flags_rd  = io_rd & sel_flags;
  assign flags_wr  = io_wr & sel_flags;

  logic unused_dout;
  assign unused_dout = ^io_dout[15:8];

  // ---------------- transmitter ----------------
  uart_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg;
  logic          tx_ready;

  assign tx_ready = (tx_state == ST_IDLE);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: if (data_wr) begin
          tx_shreg <= io_dout[7:0];
          tx_cnt   <= '0;
          tx_bit   <= '0;
          uart_tx  <= 1'b0;
          tx_state <= ST_START;
        end
        ST_START: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          uart_tx  <= tx_shreg[0];
          tx_state <= ST_DATA;
        end else tx_cnt <= tx_cnt + 1'b1;
        ST_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            uart_tx  <= 1'b1;
            tx_state <= ST_STOP;
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            uart_tx  <= tx_shreg[1];
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        ST_STOP: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_state <= ST_IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic          rx_meta, rx_sync, rx_prev;
  uart_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg;
  logic          rx_stop_sample, rx_push, rx_frame_err;

  assign rx_stop_sample = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST);
  assign rx_push        = rx_stop_sample & rx_sync;
  assign rx_frame_err   = rx_stop_sample & ~rx_sync;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (rx_state)
        ST_IDLE: if (rx_prev && !rx_sync) begin
          rx_cnt   <= '0;
          rx_state <= ST_START;
        end
        // a start bit that is high again at its mid-point is treated as a glitch
        ST_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_sync ? ST_IDLE : ST_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        ST_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shreg <= {rx_sync, rx_shreg[7:1]};
          if (rx_bit == 3'd7) rx_state <= ST_STOP;
          else                rx_bit   <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        ST_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_state <= rx_sync ? ST_IDLE : ST_BREAK;
        end else rx_cnt <= rx_cnt + 1'b1;
        ST_BREAK: if (rx_sync) rx_state <= ST_IDLE;
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .resetq(resetq),
    .push  (rx_push),
    .pop   (data_rd),
    .din   (rx_shreg),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // ---------------- status / control ----------------
  logic irq_en, overrun, framing_err;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      irq_en            <= 1'b0;
      overrun           <= 1'b0;
      framing_err       <= 1'b0;
      interrupt_request <= 1'b0;
    end else begin
      if (flags_wr) irq_en <= io_dout[4];
      // a fresh error on the clearing edge is kept rather than lost
      overrun           <= (overrun & ~flags_rd) | (rx_push & fifo_full & ~data_rd);
      framing_err       <= (framing_err & ~flags_rd) | rx_frame_err;
      interrupt_request <= irq_en & ~fifo_empty;
    end
  end

  logic [15:0] flags;

  always_comb begin
    flags                = '0;
    flags[FLAG_TX_READY] = tx_ready;
    flags[FLAG_RX_VALID] = ~fifo_empty;
    flags[FLAG_OVERRUN]  = overrun;
    flags[FLAG_FRAMING]  = framing_err;
    flags[FLAG_IRQ_EN]   = irq_en;
    io_din               = '0;
    if (sel_data)       io_din = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
    else if (sel_flags) io_din = flags;
  end

endmodule
